// File: rtl/player_damage_ctrl_pkg.sv
// Shared game definitions: damage FSM encoding, position field slices and
// default timing constants used by the player and enemy blocks.
package player_damage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_KNOCKBACK = 2'd1,
        ST_INVULN    = 2'd2,
        ST_DEAD      = 2'd3
    } dmg_state_t;

    // Packed position word is {x, y}, 10 bits each
    localparam int X_HI = 19;
    localparam int X_LO = 10;
    localparam int Y_HI = 9;
    localparam int Y_LO = 0;

    localparam int DEF_MAX_HEALTH    = 3;
    localparam int DEF_KB_FRAMES     = 8;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_STOMP_MARGIN  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned bounding box overlap of two boxes given as top-left corner
// plus size. Right/bottom edges are formed at 11 bits so screen-edge boxes
// never wrap; boxes that only share an edge do not overlap.
module aabb_overlap (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] a_w,
    input  logic [9:0] a_h,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] b_w,
    input  logic [9:0] b_h,
    output logic       overlap
);

    logic [10:0] a_right;
    logic [10:0] a_bottom;
    logic [10:0] b_right;
    logic [10:0] b_bottom;

    // Strict inequalities on all four separating axes
    always_comb begin
        a_right  = {1'b0, a_x} + {1'b0, a_w};
        a_bottom = {1'b0, a_y} + {1'b0, a_h};
        b_right  = {1'b0, b_x} + {1'b0, b_w};
        b_bottom = {1'b0, b_y} + {1'b0, b_h};
        overlap  = ({1'b0, a_x} < b_right)  && ({1'b0, b_x} < a_right) &&
                   ({1'b0, a_y} < b_bottom) && ({1'b0, b_y} < a_bottom);
    end

endmodule

// File: rtl/player_damage_ctrl.sv
// Player damage controller: classifies player/enemy contact as stomp or side
// hit on each frame tick and runs the health / knockback / invulnerability /
// death state machine. All outputs are registered.
module player_damage_ctrl
    import player_damage_ctrl_pkg::*;
#(
    parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
    parameter int KB_FRAMES     = DEF_KB_FRAMES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int STOMP_MARGIN  = DEF_STOMP_MARGIN
) (
    input  logic        sim_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic [19:0] playerPos,
    input  logic [9:0]  player_width,
    input  logic [9:0]  player_height,
    input  logic        player_falling,
    input  logic [19:0] enemyPos,
    input  logic [9:0]  enemy_width,
    input  logic [9:0]  enemy_height,
    input  logic        enemy_alive,
    input  logic        respawn,
    output logic [2:0]  health,
    output logic        hit_pulse,
    output logic        enemy_kill,
    output logic        knockback_active,
    output logic        knockback_dir,
    output logic        invuln,
    output logic        dead
);

    localparam int CNT_MAX = max_int(KB_FRAMES, INVULN_FRAMES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counter holds "ticks left minus one", so each timed state lasts N ticks
    localparam logic [CNT_W-1:0] KB_LOAD     = CNT_W'(KB_FRAMES - 1);
    localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [2:0]       HEALTH_FULL = 3'(MAX_HEALTH);

    logic [9:0]  px;
    logic [9:0]  py;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic        overlap;
    logic        contact;
    logic        stomp;
    logic        side_hit;
    logic [10:0] player_bottom;
    logic [10:0] stomp_line;

    dmg_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       health_reg, health_next;
    logic             hit_pulse_reg, hit_pulse_next;
    logic             enemy_kill_reg, enemy_kill_next;
    logic             knockback_dir_reg, knockback_dir_next;
    logic             knockback_active_reg;
    logic             invuln_reg;
    logic             dead_reg;

    assign px = playerPos[X_HI:X_LO];
    assign py = playerPos[Y_HI:Y_LO];
    assign ex = enemyPos[X_HI:X_LO];
    assign ey = enemyPos[Y_HI:Y_LO];

    aabb_overlap u_overlap (
        .a_x     (px),
        .a_y     (py),
        .a_w     (player_width),
        .a_h     (player_height),
        .b_x     (ex),
        .b_y     (ey),
        .b_w     (enemy_width),
        .b_h     (enemy_height),
        .overlap (overlap)
    );

    // Contact classification; a stomp always takes precedence over a side hit
    always_comb begin
        player_bottom = {1'b0, py} + {1'b0, player_height};
        stomp_line    = {1'b0, ey} + 11'(STOMP_MARGIN);
        contact       = overlap && enemy_alive;
        stomp         = contact && player_falling && (player_bottom <= stomp_line);
        side_hit      = contact && !stomp;
    end

    // Next-state, counter, health and strobe logic; only frame ticks advance it
    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        health_next        = health_reg;
        hit_pulse_next     = 1'b0;
        enemy_kill_next    = 1'b0;
        knockback_dir_next = knockback_dir_reg;
        if (frame_tick) begin
            case (state_reg)
                ST_ALIVE: begin
                    if (stomp) begin
                        enemy_kill_next = 1'b1;
                    end else if (side_hit && (health_reg != 3'd0)) begin
                        hit_pulse_next     = 1'b1;
                        health_next        = health_reg - 3'd1;
                        knockback_dir_next = (px >= ex);
                        if (health_reg == 3'd1) begin
                            state_next = ST_DEAD;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_KNOCKBACK;
                            cnt_next   = KB_LOAD;
                        end
                    end
                end
                ST_KNOCKBACK: begin
                    enemy_kill_next = stomp;
                    if (cnt_reg == '0) begin
                        state_next = ST_INVULN;
                        cnt_next   = INVULN_LOAD;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_INVULN: begin
                    enemy_kill_next = stomp;
                    if (cnt_reg == '0) begin
                        state_next = ST_ALIVE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_DEAD: begin
                    if (respawn) begin
                        health_next = HEALTH_FULL;
                        state_next  = ST_INVULN;
                        cnt_next    = INVULN_LOAD;
                    end
                end
                default: begin
                    state_next = ST_ALIVE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State and registered outputs, asynchronously cleared by reset_n
    always_ff @(posedge sim_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg            <= ST_ALIVE;
            cnt_reg              <= '0;
            health_reg           <= HEALTH_FULL;
            hit_pulse_reg        <= 1'b0;
            enemy_kill_reg       <= 1'b0;
            knockback_dir_reg    <= 1'b0;
            knockback_active_reg <= 1'b0;
            invuln_reg           <= 1'b0;
            dead_reg             <= 1'b0;
        end else begin
            state_reg            <= state_next;
            cnt_reg              <= cnt_next;
            health_reg           <= health_next;
            hit_pulse_reg        <= hit_pulse_next;
            enemy_kill_reg       <= enemy_kill_next;
            knockback_dir_reg    <= knockback_dir_next;
            knockback_active_reg <= (state_next == ST_KNOCKBACK);
            invuln_reg           <= (state_next == ST_KNOCKBACK) || (state_next == ST_INVULN);
            dead_reg             <= (state_next == ST_DEAD);
        end
    end

    assign health           = health_reg;
    assign hit_pulse        = hit_pulse_reg;
    assign enemy_kill       = enemy_kill_reg;
    assign knockback_active = knockback_active_reg;
    assign knockback_dir    = knockback_dir_reg;
    assign invuln           = invuln_reg;
    assign dead             = dead_reg;

endmodule

// File: doc/player_damage_ctrl.md
# player_damage_ctrl

Player-side consumer of the enemy position/collision interface. It samples one enemy's bounding box against the player's box on every game frame tick. A side contact costs the player health and triggers knockback followed by invulnerability. A stomp, where the player lands on the enemy from above, kills the enemy without damage. It sits between the enemy movers and the player physics/HUD, and drives health, knockback and enemy-kill strobes.

## Interface
- `MAX_HEALTH`, default 3: health after reset and after respawn (1..7).
- `KB_FRAMES`, default 8: frame ticks spent in knockback.
- `INVULN_FRAMES`, default 60: frame ticks of invulnerability after knockback or respawn.
- `STOMP_MARGIN`, default 4: pixels; the player bottom may sit this far below the enemy top and still count as a stomp.
- `sim_clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle game-update strobe; all state changes happen only on cycles where it is high.
- `playerPos`  in  20  {x[19:10], y[9:0]}, player top-left corner.
- `player_width`, `player_height`  in  10 each  player box size.
- `player_falling`  in  1  player vertical velocity is downward.
- `enemyPos`  in  20  {x, y}, enemy top-left corner.
- `enemy_width`, `enemy_height`  in  10 each  enemy box size.
- `enemy_alive`  in  1  enemy is present; contact is ignored when low.
- `respawn`  in  1  level input; sampled only in DEAD on a frame tick.
- `health`  out  3  remaining health.
- `hit_pulse`  out  1  one-cycle strobe on a damaging contact.
- `enemy_kill`  out  1  one-cycle strobe on a stomp.
- `knockback_active`  out  1  high in KNOCKBACK.
- `knockback_dir`  out  1  1 = push right, 0 = push left.
- `invuln`  out  1  high in KNOCKBACK and INVULN.
- `dead`  out  1  high in DEAD.

## Operation
- Overlap test, computed at 11 bits so no sum wraps. Overlap is true when all four hold:
  - px < ex+ew
  - ex < px+pw
  - py < ey+eh
  - ey < py+ph
  - Edges that only touch do not count as overlap.
- contact = overlap && enemy_alive.
- stomp = contact && player_falling && (py+ph) <= (ey+STOMP_MARGIN). Compare at 11 bits.
- side_hit = contact && !stomp.
- States and transitions, evaluated only when frame_tick is high:
  - ALIVE:
    - If stomp: enemy_kill for 1 cycle, stay in ALIVE.
    - Else if side_hit: health decrements, hit_pulse for 1 cycle. knockback_dir = (px >= ex).
    - After a side_hit, go to DEAD if the new health is 0. Otherwise go to KNOCKBACK and load the counter with KB_FRAMES-1.
  - KNOCKBACK: side hits are ignored; stomps still kill. The counter decrements each tick; on a tick with counter = 0, go to INVULN and load INVULN_FRAMES-1.
  - INVULN: same rules as KNOCKBACK; on a tick with counter = 0, go to ALIVE.
  - DEAD: all contact is ignored. If respawn is high on a tick: health = MAX_HEALTH, go to INVULN, load INVULN_FRAMES-1.
- Duration of each timed state is therefore exactly KB_FRAMES or INVULN_FRAMES ticks.
- Health never underflows. DEAD is entered exactly when health reaches 0.
- Counter width is $clog2(max(KB_FRAMES, INVULN_FRAMES)).

## Timing
- Reset values:
  - state ALIVE, health = MAX_HEALTH, counter = 0
  - hit_pulse, enemy_kill, knockback_active, knockback_dir, invuln, dead all 0
- All outputs are registered.
- Inputs are sampled on the tick cycle. The state, strobes and health update on the following edge, i.e. 1-cycle latency from tick to outputs.
- Strobes are exactly 1 cycle wide and are never asserted on non-tick cycles.
- Inputs that change between ticks have no effect.
- Reset is asynchronous and effective mid-knockback or in DEAD: on reset assertion, all outputs go to their reset values immediately and the counter clears.
- If stomp and side_hit conditions compete in the same tick, stomp wins; they are mutually exclusive by definition.

## Structure
- Shared game package holds:
  - the state encoding (ALIVE, KNOCKBACK, INVULN, DEAD)
  - the position field slices (X_HI = 19, X_LO = 10, Y_HI = 9, Y_LO = 0)
  - the default timing constants
- Sub-module `aabb_overlap`: purely combinational, 11-bit overlap of two boxes. It is reused by the enemy movers and by future pickups.
- FSM, counter and health register live in the top module.

## Test plan
- **Side hit.** Player (100,200) 16×16; enemy (110,200) 16×16; enemy_alive = 1; not falling; one tick.
  - hit_pulse for 1 cycle, health 3→2, knockback_dir = 0.
  - knockback_active for 8 ticks, then invuln alone for 60 ticks, then ALIVE.
- **Stomp.** Player (110,186) 16×16, falling; enemy (110,200). Player bottom 202 ≤ 204.
  - enemy_kill for 1 cycle, health unchanged.
  - Repeat with player y = 190 (bottom 206 > 204): a side hit results instead.
- **Invulnerability.** Continuous overlap across 68 ticks after the first hit.
  - Only one hit_pulse.
  - A second hit occurs on the first tick after ALIVE resumes.
- **Death and respawn.** Three separated hits.
  - Health 3→2→1→0; dead rises with the third hit.
  - Overlap while dead does nothing.
  - respawn on a tick: health = 3, invuln for 60 ticks.
- **Edge cases.**
  - Touching edges, e.g. px+pw = ex, give no hit.
  - ex = 1015, ew = 16 (sum exceeds 10 bits) still gives a correct overlap result.
  - enemy_alive = 0 gives no hit.
- **Reset mid-knockback.** reset_n low for 1 cycle during knockback.
  - Outputs return to reset values asynchronously; health = 3.
